// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters, with a held result.
// Optional response timeout is enabled by defining ALU_ARB_RSP_TIMEOUT_EN.
module alu_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CTRL_WIDTH = 3
`ifdef ALU_ARB_RSP_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [CTRL_WIDTH-1:0] req0_ctrl,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [DATA_WIDTH-1:0] rsp0_data,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [CTRL_WIDTH-1:0] req1_ctrl,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [DATA_WIDTH-1:0] rsp1_data,
  output logic [CTRL_WIDTH-1:0] alu_ctrl,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic                  busy
`ifdef ALU_ARB_RSP_TIMEOUT_EN
  ,
  output logic                  rsp_timeout
`endif
);

  localparam logic [CTRL_WIDTH-1:0] CtrlAdd = CTRL_WIDTH'(3'b010);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e                state_q, state_d;
  logic                  ptr_q;
  logic                  owner_q;
  logic [CTRL_WIDTH-1:0] alu_ctrl_q;
  logic [DATA_WIDTH-1:0] alu_a_q, alu_b_q;
  logic                  rsp0_valid_q, rsp1_valid_q;
  logic [DATA_WIDTH-1:0] rsp0_data_q, rsp1_data_q;

  logic gnt0, gnt1;
  logic hs0, hs1, hs_any;
  logic owner_ack;
  logic timeout_fire;
  logic rsp_done;

  // ptr_q == 0 favours port 0 when both request.
  assign gnt0      = req0_valid & (~req1_valid | ~ptr_q);
  assign gnt1      = req1_valid & (~req0_valid | ptr_q);
  assign hs0       = req0_valid & req0_ready;
  assign hs1       = req1_valid & req1_ready;
  assign hs_any    = hs0 | hs1;
  assign owner_ack = owner_q ? rsp1_ready : rsp0_ready;

`ifdef ALU_ARB_RSP_TIMEOUT_EN
  localparam int unsigned     CntW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q;
  logic            timeout_q;

  // A ready on the final RESP cycle takes priority over the timeout.
  assign timeout_fire = (state_q == StResp) & ~owner_ack & (cnt_q == CntLast);
  assign rsp_timeout  = timeout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_fire;
      if (state_q == StResp) begin
        cnt_q <= cnt_q + CntW'(1);
      end else begin
        cnt_q <= '0;
      end
    end
  end
`else
  assign timeout_fire = 1'b0;
`endif

  assign rsp_done = (state_q == StResp) & (owner_ack | timeout_fire);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (hs_any) state_d = StExec;
      StExec:  state_d = StResp;
      StResp:  if (rsp_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs: grants are only offered in IDLE and never while reset is asserted.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    busy       = (state_q != StIdle);
    if ((state_q == StIdle) && !rst) begin
      req0_ready = gnt0;
      req1_ready = gnt1;
    end
  end

  // Operand capture, ownership, pointer and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q        <= 1'b0;
      owner_q      <= 1'b0;
      alu_ctrl_q   <= CtrlAdd;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
    end else begin
      if (hs_any) begin
        alu_ctrl_q <= hs1 ? req1_ctrl : req0_ctrl;
        alu_a_q    <= hs1 ? req1_a : req0_a;
        alu_b_q    <= hs1 ? req1_b : req0_b;
        owner_q    <= hs1;
        ptr_q      <= hs0;
      end
      if (state_q == StExec) begin
        if (owner_q) begin
          rsp1_data_q  <= alu_result;
          rsp1_valid_q <= 1'b1;
        end else begin
          rsp0_data_q  <= alu_result;
          rsp0_valid_q <= 1'b1;
        end
      end
      if (rsp_done) begin
        rsp0_valid_q <= 1'b0;
        rsp1_valid_q <= 1'b0;
      end
    end
  end

  assign alu_ctrl   = alu_ctrl_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp1_data  = rsp1_data_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus random traffic against a
// transaction-level reference model. Covers rsp_timeout when ALU_ARB_RSP_TIMEOUT_EN is defined.
module tb_alu_arbiter;

  localparam int TimeoutCycles = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready;
  logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready;
  logic [2:0]  req0_ctrl, req1_ctrl, alu_ctrl;
  logic [31:0] req0_a, req0_b, req1_a, req1_b, rsp0_data, rsp1_data;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        busy;
`ifdef ALU_ARB_RSP_TIMEOUT_EN
  logic        rsp_timeout;
`endif

  int n_errors = 0;
  int n_checks = 0;

  alu_arbiter #(
    .DATA_WIDTH(32),
    .CTRL_WIDTH(3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_ctrl (req0_ctrl),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .rsp0_valid(rsp0_valid),
    .rsp0_ready(rsp0_ready),
    .rsp0_data (rsp0_data),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_ctrl (req1_ctrl),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .rsp1_valid(rsp1_valid),
    .rsp1_ready(rsp1_ready),
    .rsp1_data (rsp1_data),
    .alu_ctrl  (alu_ctrl),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_result(alu_result),
    .busy      (busy)
`ifdef ALU_ARB_RSP_TIMEOUT_EN
    ,
    .rsp_timeout(rsp_timeout)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(input logic [2:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    case (c)
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b111:  return a << b[4:0];
      3'b011:  return a >> b[4:0];
      3'b100:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return a * b;
    endcase
  endfunction

  assign alu_result = alu_ref(alu_ctrl, alu_a, alu_b);

  // Reference model: one in-flight transaction and its age in cycles since the grant.
  bit          m_active, m_owner, m_ptr, m_to;
  int          m_age;
  logic [2:0]  m_ctrl;
  logic [31:0] m_a, m_b;
  logic [31:0] m_data[2];
  int          cyc;
  int          gnt_port[$];
  int          gnt_cyc[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_owner = 0; m_ptr = 0; m_to = 0; m_age = 0;
    m_ctrl = 3'b010; m_a = '0; m_b = '0;
    m_data[0] = '0; m_data[1] = '0;
  endtask

  task automatic set_req(input int p, input bit v, input logic [2:0] c, input logic [31:0] a,
                         input logic [31:0] b);
    if (p == 0) begin
      req0_valid = v; req0_ctrl = c; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_ctrl = c; req1_a = a; req1_b = b;
    end
  endtask

  // Check this cycle's outputs at the falling edge, then advance the model across the next edge.
  task automatic step();
    bit has_win, win;
    @(negedge clk);
    has_win = 0;
    win     = 0;
    if (!m_active && !rst) begin
      if (req0_valid && req1_valid) begin
        has_win = 1; win = m_ptr;
      end else if (req0_valid) begin
        has_win = 1; win = 0;
      end else if (req1_valid) begin
        has_win = 1; win = 1;
      end
    end
    check_eq("busy", busy, m_active);
    check_eq("req0_ready", req0_ready, has_win && !win);
    check_eq("req1_ready", req1_ready, has_win && win);
    check_eq("rsp0_valid", rsp0_valid, m_active && m_age >= 2 && !m_owner);
    check_eq("rsp1_valid", rsp1_valid, m_active && m_age >= 2 && m_owner);
    check_eq("rsp0_data", rsp0_data, m_data[0]);
    check_eq("rsp1_data", rsp1_data, m_data[1]);
    check_eq("alu_ctrl", alu_ctrl, m_ctrl);
    check_eq("alu_a", alu_a, m_a);
    check_eq("alu_b", alu_b, m_b);
`ifdef ALU_ARB_RSP_TIMEOUT_EN
    check_eq("rsp_timeout", rsp_timeout, m_to);
`endif
    if (req0_valid && req0_ready) begin gnt_port.push_back(0); gnt_cyc.push_back(cyc); end
    if (req1_valid && req1_ready) begin gnt_port.push_back(1); gnt_cyc.push_back(cyc); end
    m_to = 0;
    if (rst) begin
      model_reset();
    end else if (!m_active) begin
      if (has_win) begin
        m_active = 1; m_age = 1; m_owner = win; m_ptr = !win;
        m_ctrl = win ? req1_ctrl : req0_ctrl;
        m_a    = win ? req1_a : req0_a;
        m_b    = win ? req1_b : req0_b;
      end
    end else if (m_age == 1) begin
      m_data[m_owner] = alu_ref(m_ctrl, m_a, m_b);
      m_age = 2;
    end else if (m_owner ? rsp1_ready : rsp0_ready) begin
      m_active = 0;
`ifdef ALU_ARB_RSP_TIMEOUT_EN
    end else if (m_age - 1 == TimeoutCycles) begin
      m_active = 0;
      m_to     = 1;
`endif
    end else begin
      m_age++;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_cycle();
    rst = 1;
    step();
    rst = 0;
  endtask

  initial begin
    logic [31:0] held;
    int          pulses;
    rst = 1;
    set_req(0, 0, 3'b000, '0, '0);
    set_req(1, 0, 3'b000, '0, '0);
    rsp0_ready = 1;
    rsp1_ready = 1;
    cyc = 0;
    model_reset();
    @(posedge clk);
    #1;
    step();
    rst = 0;

    // Single add from port 0.
    set_req(0, 1, 3'b010, 32'd5, 32'd7);
    step();
    set_req(0, 0, 3'b000, '0, '0);
    check_eq("t1_exec_ctrl", alu_ctrl, 3'b010);
    check_eq("t1_exec_a", alu_a, 32'd5);
    check_eq("t1_exec_b", alu_b, 32'd7);
    check_eq("t1_exec_busy", busy, 1'b1);
    step();
    check_eq("t1_rsp_valid", rsp0_valid, 1'b1);
    check_eq("t1_rsp_data", rsp0_data, 32'd12);
    step();
    check_eq("t1_idle_busy", busy, 1'b0);

    // Simultaneous requests straight after reset.
    reset_cycle();
    gnt_port.delete(); gnt_cyc.delete();
    set_req(0, 1, 3'b110, 32'd10, 32'd3);
    set_req(1, 1, 3'b001, 32'hF0, 32'h0F);
    step();
    step();
    check_eq("t2_rsp0_data", rsp0_data, 32'd7);
    check_eq("t2_rsp1_quiet", rsp1_valid, 1'b0);
    step();
    step();
    set_req(0, 0, 3'b000, '0, '0);
    set_req(1, 0, 3'b000, '0, '0);
    step();
    check_eq("t2_rsp1_valid", rsp1_valid, 1'b1);
    check_eq("t2_rsp1_data", rsp1_data, 32'hFF);
    check_eq("t2_gnt_count", gnt_port.size(), 2);
    if (gnt_port.size() == 2) begin
      check_eq("t2_first", gnt_port[0], 0);
      check_eq("t2_second", gnt_port[1], 1);
    end
    step();

    // Backpressure on port 1 while port 0 waits.
    rsp1_ready = 0;
    set_req(1, 1, 3'b001, 32'h12, 32'h21);
    step();
    set_req(1, 0, 3'b000, '0, '0);
    set_req(0, 1, 3'b010, 32'd1, 32'd2);
    step();
    held = rsp1_data;
    check_eq("t3_data", held, 32'h33);
    for (int i = 0; i < 5; i++) begin
      check_eq("t3_hold_valid", rsp1_valid, 1'b1);
      check_eq("t3_hold_data", rsp1_data, held);
      check_eq("t3_req0_blocked", req0_ready, 1'b0);
      step();
    end
    rsp1_ready = 1;
    step();
    set_req(0, 0, 3'b000, '0, '0);
    repeat (3) step();

    // Saturation fairness.
    reset_cycle();
    gnt_port.delete(); gnt_cyc.delete();
    set_req(0, 1, 3'b101, 32'd6, 32'd9);
    set_req(1, 1, 3'b111, 32'd1, 32'd4);
    repeat (12) step();
    set_req(0, 0, 3'b000, '0, '0);
    set_req(1, 0, 3'b000, '0, '0);
    repeat (3) step();
    check_eq("t4_gnt_count", gnt_port.size(), 4);
    for (int i = 0; i < gnt_port.size(); i++) begin
      check_eq("t4_port", gnt_port[i], i % 2);
      if (i > 0) check_eq("t4_gap", gnt_cyc[i] - gnt_cyc[i-1], 3);
    end

    // Reset during EXEC.
    set_req(0, 1, 3'b100, 32'hFFFF_FFFF, 32'd1);
    step();
    set_req(0, 0, 3'b000, '0, '0);
    rst = 1;
    step();
    rst = 0;
    check_eq("t5_busy", busy, 1'b0);
    check_eq("t5_rsp0_valid", rsp0_valid, 1'b0);
    check_eq("t5_rsp1_valid", rsp1_valid, 1'b0);
    check_eq("t5_alu_ctrl", alu_ctrl, 3'b010);
    gnt_port.delete(); gnt_cyc.delete();
    set_req(0, 1, 3'b011, 32'h80, 32'd3);
    set_req(1, 1, 3'b000, 32'hFF, 32'h0F);
    step();
    set_req(0, 0, 3'b000, '0, '0);
    set_req(1, 0, 3'b000, '0, '0);
    check_eq("t5_gnt_count", gnt_port.size(), 1);
    if (gnt_port.size() == 1) check_eq("t5_gnt_port", gnt_port[0], 0);
    repeat (3) step();

`ifdef ALU_ARB_RSP_TIMEOUT_EN
    // Timeout with no ready, then ready on the last allowed cycle.
    rsp0_ready = 0;
    set_req(0, 1, 3'b010, 32'd3, 32'd4);
    step();
    set_req(0, 0, 3'b000, '0, '0);
    step();
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (rsp_timeout) begin
        pulses++;
        check_eq("t6_valid_drop", rsp0_valid, 1'b0);
      end
    end
    check_eq("t6_pulses", pulses, 1);
    set_req(0, 1, 3'b010, 32'd8, 32'd8);
    step();
    set_req(0, 0, 3'b000, '0, '0);
    step();
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (rsp_timeout) pulses++;
    end
    rsp0_ready = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (rsp_timeout) pulses++;
    end
    check_eq("t6_no_pulse", pulses, 0);
`else
    pulses = 0;
    held   = '0;
`endif

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      rst        = ($urandom_range(0, 63) == 0);
      set_req(0, 1'($urandom_range(0, 1)), 3'($urandom), $urandom, $urandom);
      set_req(1, 1'($urandom_range(0, 1)), 3'($urandom), $urandom, $urandom);
      rsp0_ready = ($urandom_range(0, 3) != 0);
      rsp1_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single-cycle core's one ALU between two requesters: port 0 is the core's multi-cycle helper path, and port 1 is the UART debug/command path.
- Round-robin grant, valid/ready request handshake, operand capture.
- Drives the ALU with the standard 3-bit ALUControl encoding and registers the result.
- Holds the result until the owning requester accepts it.
- Sits between the requesters and the ALU instance, in parallel with the core's normal ALU_Control path; top-level muxing is outside this block.

Parameters:
DATA_WIDTH, 32, operand/result width
CTRL_WIDTH, 3, ALU control code width (010 add, 110 sub, 000 and, 001 or, 111 sll, 011 srl, 100 slt, 101 mul)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_ctrl  in  CTRL_WIDTH  requester 0 ALU control code
req0_a  in  DATA_WIDTH  requester 0 operand A
req0_b  in  DATA_WIDTH  requester 0 operand B
rsp0_valid  out  1  result for requester 0 available
rsp0_ready  in  1  requester 0 takes result
rsp0_data  out  DATA_WIDTH  result for requester 0
req1_valid, req1_ready, req1_ctrl, req1_a, req1_b, rsp1_valid, rsp1_ready, rsp1_data: same as port 0, for requester 1
alu_ctrl  out  CTRL_WIDTH  control code to ALU
alu_a  out  DATA_WIDTH  operand A to ALU
alu_b  out  DATA_WIDTH  operand B to ALU
alu_result  in  DATA_WIDTH  combinational ALU result
busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset values:
  - State IDLE.
  - Round-robin pointer favours port 0.
  - Owner register 0.
  - alu_ctrl=3'b010; alu_a=0; alu_b=0.
  - rsp*_valid=0; rsp*_data=0; busy=0.
  - req*_ready=0 while rst is high.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - req*_ready is combinational and one-hot: high only for the granted port.
  - Grant rule: if only one valid is high, that port wins. If both are high, the port named by the pointer wins.
  - On handshake (valid & ready):
    - Latch ctrl/a/b into the operand registers.
    - Record the owner.
    - Set the pointer to the other port.
    - Go to EXEC.
  - With no valid, stay in IDLE; the pointer is unchanged.
- EXEC:
  - alu_ctrl/alu_a/alu_b come from the operand registers; these outputs are always register-driven, never taken directly from req inputs.
  - At the end of the cycle, capture alu_result into the owner's rsp_data and set its rsp_valid. Go to RESP.
- RESP:
  - The owner's rsp_valid is held high and rsp_data is held stable until rsp_ready.
  - On rsp_ready, clear rsp_valid and go to IDLE.
  - No new grant is issued in the same cycle as rsp_ready. Minimum issue interval is 3 cycles.
  - The non-owner's rsp_valid stays 0.
- Latency: handshake at cycle N -> rsp_valid high at N+2 (visible after edge N+2).
- ALU outputs outside EXEC: alu_ctrl/a/b keep their last EXEC values; they are not re-zeroed.
- Control codes: all 8 codes are passed through unmodified; the arbiter does not decode or check ops.
- Arbitration is only sampled in IDLE:
  - A requester deasserting valid without a handshake is not an error; it simply gets no grant.
  - Valid asserted during EXEC/RESP waits.
- Reset mid-operation: return to the reset values on the next edge. Any in-flight result is discarded and no rsp_valid is produced.
- Fairness: with both valids held continuously, grants alternate 0,1,0,1,...

Optional Feature:
ALU_ARB_RSP_TIMEOUT_EN
- Defined:
  - Adds output rsp_timeout (1 bit) and parameter TIMEOUT_CYCLES (default 16).
  - A counter starts at entry to RESP. If rsp_ready is not seen within TIMEOUT_CYCLES cycles, clear rsp_valid, pulse rsp_timeout high for 1 cycle, and go to IDLE.
  - rsp_ready on the final cycle wins over the timeout.
  - Counter and rsp_timeout reset to 0.
- Undefined: no port, no counter; RESP waits indefinitely.

Test Plan:
1. Reset then single op:
   - Stimulus: req0_valid, ctrl=010, a=5, b=7; ALU model returns 12; rsp0_ready=1.
   - Response: req0_ready at N; alu_ctrl=010/a=5/b=7 during N+1; rsp0_valid=1 with rsp0_data=12 at N+2; back to IDLE at N+3; busy high N+1..N+2.
2. Simultaneous requests from reset:
   - Stimulus: both valid; port0 sub 10-3, port1 or 0xF0|0x0F.
   - Response: port0 granted first (rsp0_data=7); port1 granted next (rsp1_data=0xFF); rsp1_valid never high during port0's transaction.
3. Backpressure:
   - Stimulus: rsp1_ready held 0 for 5 cycles.
   - Response: rsp1_valid and rsp1_data stable for all 5 cycles; req0_ready stays 0 throughout even with req0_valid=1.
4. Fairness under saturation:
   - Stimulus: both valids high for 12 cycles, rsp_ready=1.
   - Response: grant sequence 0,1,0,1; one grant per 3 cycles.
5. Reset mid-EXEC:
   - Stimulus: assert rst during EXEC.
   - Response: busy=0, rsp*_valid=0, alu_ctrl=010 on the next edge; the next request from port0 and port1 together grants port0.
6. (ALU_ARB_RSP_TIMEOUT_EN) Timeout:
   - Stimulus: rsp0_ready=0 for 20 cycles.
   - Response: rsp_timeout pulses once, 16 cycles after entry to RESP; rsp0_valid drops the same cycle; with rsp0_ready asserted on cycle 16, no pulse occurs.
